// File: rtl/button_debounce.sv
// Button/switch debouncer: multi-flop synchronizer, then a four-state qualification FSM.
// Emits a registered clean level, one-cycle rise/fall/enable strobes and a wrapping accepted-edge count.
module button_debounce #(
  parameter int SYNC_STAGES  = 2,
  parameter int STABLE_COUNT = 4,
  parameter int COUNT_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               raw_in,
  output logic               data_out,
  output logic               enable,
  output logic               rise,
  output logic               fall,
  output logic [COUNT_W-1:0] edge_count
);

  localparam int CNT_W = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_PEND_HI,
    ST_HIGH,
    ST_PEND_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   data_out_q, data_out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   enable_q, enable_d;
  logic [COUNT_W-1:0]     edge_count_q, edge_count_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
  assign s      = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_out_d   = data_out_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    edge_count_d = edge_count_q;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_PEND_HI;
          cnt_d   = '0;
        end
      end
      ST_PEND_HI: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_HIGH;
          cnt_d        = '0;
          data_out_d   = 1'b1;
          rise_d       = 1'b1;
          edge_count_d = edge_count_q + COUNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_PEND_LO;
          cnt_d   = '0;
        end
      end
      ST_PEND_LO: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = ST_LOW;
          cnt_d        = '0;
          data_out_d   = 1'b0;
          fall_d       = 1'b1;
          edge_count_d = edge_count_q + COUNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
    enable_d = rise_d | fall_d;
  end

  // Register stage: reset wins over a qualification completing on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      state_q      <= ST_LOW;
      cnt_q        <= '0;
      data_out_q   <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      enable_q     <= 1'b0;
      edge_count_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_out_q   <= data_out_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      enable_q     <= enable_d;
      edge_count_q <= edge_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign enable     = enable_q;
  assign rise       = rise_q;
  assign fall       = fall_q;
  assign edge_count = edge_count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench for button_debounce: a run-length reference model predicts every cycle's outputs,
// a monitor compares them; a second instance with COUNT_W=2 exercises counter wrap.
module tb_button_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       raw_in;
  logic       data_out, enable, rise, fall;
  logic [7:0] edge_count;
  logic       data_out2, enable2, rise2, fall2;
  logic [1:0] edge_count2;

  button_debounce #(.SYNC_STAGES(SYNC), .STABLE_COUNT(STABLE), .COUNT_W(8)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .data_out(data_out), .enable(enable), .rise(rise), .fall(fall),
    .edge_count(edge_count)
  );

  button_debounce #(.SYNC_STAGES(SYNC), .STABLE_COUNT(STABLE), .COUNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .raw_in(raw_in),
    .data_out(data_out2), .enable(enable2), .rise(rise2), .fall(fall2),
    .edge_count(edge_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       d;
    logic       r;
    logic       f;
    logic       e;
    logic [7:0] c;
    logic [1:0] c2;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the FSM sees raw_in delayed by SYNC edges; a new level is accepted
  // once STABLE+1 consecutive samples differ from the current level.
  logic dq[$];
  logic lvl = 1'b0;
  int   run = 0;
  int   cnt = 0;
  int   model_edges = 0;

  initial begin
    for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
  end

  always @(posedge clk) begin
    exp_t e;
    logic smp;
    e = '0;
    if (reset) begin
      dq.delete();
      for (int i = 0; i < SYNC; i++) dq.push_back(1'b0);
      lvl = 1'b0;
      run = 0;
      cnt = 0;
    end else begin
      smp = dq.pop_front();
      dq.push_back(raw_in);
      if (smp != lvl) run++;
      else run = 0;
      if (run == STABLE + 1) begin
        lvl = smp;
        run = 0;
        cnt++;
        model_edges++;
        e.r = smp;
        e.f = ~smp;
        e.e = 1'b1;
      end
    end
    e.d  = lvl;
    e.c  = 8'(cnt);
    e.c2 = 2'(cnt);
    exp_q.push_back(e);
  end

  logic wrap_win = 1'b0;
  logic [1:0] wrap_seq[$];
  int dut_edges = 0;

  always @(negedge clk) begin
    exp_t ex;
    logic [13:0] got1, got2, want1, want2;
    if (exp_q.size() != 0) begin
      ex = exp_q.pop_front();
      got1  = {data_out, rise, fall, enable, edge_count, 2'b00};
      want1 = {ex.d, ex.r, ex.f, ex.e, ex.c, 2'b00};
      got2  = {data_out2, rise2, fall2, enable2, 8'h00, edge_count2};
      want2 = {ex.d, ex.r, ex.f, ex.e, 8'h00, ex.c2};
      n_tests++;
      if (got1 !== want1) begin
        n_fail++;
        $display("FAIL outputs_w8 t=%0t got d/r/f/e/cnt=%b%b%b%b/%0d want %b%b%b%b/%0d",
                 $time, data_out, rise, fall, enable, edge_count, ex.d, ex.r, ex.f, ex.e, ex.c);
      end
      n_tests++;
      if (got2 !== want2) begin
        n_fail++;
        $display("FAIL outputs_w2 t=%0t got d/r/f/e/cnt=%b%b%b%b/%0d want %b%b%b%b/%0d",
                 $time, data_out2, rise2, fall2, enable2, edge_count2, ex.d, ex.r, ex.f, ex.e, ex.c2);
      end
    end
    if (enable === 1'b1) dut_edges++;
    if (wrap_win && enable2 === 1'b1) wrap_seq.push_back(edge_count2);
  end

  task automatic drive(input logic r, input logic rs, input int n);
    raw_in = r;
    reset  = rs;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] wrap_exp[5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    drive(1'b0, 1'b1, 3);
    drive(1'b1, 1'b0, 20);
    for (int w = 1; w <= 4; w++) begin
      drive(1'b0, 1'b0, w);
      drive(1'b1, 1'b0, 10);
    end
    drive(1'b0, 1'b0, 10);

    // Reset during a pending rise, then requalify
    drive(1'b1, 1'b0, 5);
    drive(1'b1, 1'b1, 1);
    drive(1'b1, 1'b0, 12);
    drive(1'b0, 1'b0, 12);

    // Reset lands exactly on the completing edge
    drive(1'b1, 1'b0, 6);
    drive(1'b1, 1'b1, 1);
    drive(1'b0, 1'b1, 2);
    drive(1'b0, 1'b0, 3);

    wrap_win = 1'b1;
    for (int i = 0; i < 5; i++) drive((i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 12);
    wrap_win = 1'b0;

    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0), $urandom_range(1, 8));
    drive(1'b0, 1'b0, 15);
    @(negedge clk);
    #1;

    n_tests++;
    if (wrap_seq.size() != 5) begin
      n_fail++;
      $display("FAIL wrap_pulses got %0d enable pulses want 5", wrap_seq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_tests++;
        if (wrap_seq[i] !== wrap_exp[i]) begin
          n_fail++;
          $display("FAIL wrap_seq[%0d] got %0d want %0d", i, wrap_seq[i], wrap_exp[i]);
        end
      end
    end

    n_tests++;
    if (dut_edges != model_edges) begin
      n_fail++;
      $display("FAIL total_edges got %0d want %0d", dut_edges, model_edges);
    end

    n_tests++;
    if (exp_q.size() > 1) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending want <=1", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the sequential-lab flip-flop/register blocks. Takes a raw, asynchronous, bouncing switch or button input and produces a clean registered level.
- `data_out` feeds the downstream flop's data input; `enable` is a one-cycle strobe that drives its enable.
- Internal pipeline: multi-stage synchronizer, then a 4-state qualification FSM with a stability counter.
- Also keeps a running count of accepted transitions for bench and LED observation.

Parameters:
- SYNC_STAGES, 2, synchronizer depth; legal range >= 2.
- STABLE_COUNT, 4, extra consecutive stable samples required after the first changed sample; legal range >= 2.
- COUNT_W, 8, width of edge_count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  1  asynchronous raw button level.
- data_out  output  1  debounced level (registered).
- enable  output  1  one-cycle strobe on any accepted transition; equals rise|fall (registered).
- rise  output  1  one-cycle strobe on an accepted 0->1 transition.
- fall  output  1  one-cycle strobe on an accepted 1->0 transition.
- edge_count  output  COUNT_W  accepted-transition counter; wraps modulo 2^COUNT_W.

Behaviour:
- Single clock domain, clk. reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: synchronizer flops 0, state LOW, stability counter 0, data_out 0, enable/rise/fall 0, edge_count 0.
- Synchronizer: SYNC_STAGES-flop chain from raw_in. Only the last stage (s) feeds the FSM.
- Stability counter: width $clog2(STABLE_COUNT).
- FSM state LOW:
  - s=1 -> PEND_HI, counter <= 0.
- FSM state PEND_HI:
  - s=0 -> LOW (bounce rejected), no strobe, counter cleared.
  - s=1 and counter == STABLE_COUNT-1 -> HIGH; data_out<=1, rise<=1, enable<=1, edge_count++.
  - Otherwise counter++.
- FSM state HIGH:
  - s=0 -> PEND_LO, counter <= 0.
- FSM state PEND_LO: mirror of PEND_HI.
  - s=1 -> HIGH (bounce rejected).
  - Qualification complete -> LOW; data_out<=0, fall<=1, enable<=1, edge_count++.
- Strobes are high for exactly one cycle and return to 0 on the next edge.
  - rise and fall are never high together.
- Latency: raw_in changes between edges and then holds. data_out updates on edge number SYNC_STAGES + STABLE_COUNT + 1 after the change. With defaults, that is the 7th edge.
  - The strobe is visible in the same cycle that data_out changes.
- Acceptance condition: s must hold the new value for STABLE_COUNT+1 consecutive samples. Any earlier reversal returns the FSM to the prior stable state. The counter restarts from 0 on the next change.
- data_out changes only on LOW<->HIGH qualification; it never changes in PEND states.
- edge_count wraps from 2^COUNT_W-1 to 0 with no flag.
- Reset mid-PEND: abandons the qualification with no strobe and all state returns to reset values.
  - If raw_in is still high after reset deasserts, full qualification restarts. A rise strobe then follows after SYNC_STAGES + STABLE_COUNT + 1 edges, counted from the first edge with reset low.
- Reset asserted in the same cycle a qualification would complete: reset wins. No strobe, and edge_count is not incremented.
- No combinational path from raw_in to any output.

Test Plan:
All scenarios use default parameters unless stated.
- Reset for 3 cycles with raw_in=0 -> data_out=0, enable=rise=fall=0, edge_count=0 for every cycle.
- raw_in 0->1 held 20 cycles -> data_out goes 1 after edge 7; rise=enable=1 for exactly that cycle and fall=0; edge_count=1.
- From HIGH, raw_in pulses low for 1, 2, 3 and 4 cycles, separated by 10 high cycles -> data_out stays 1, no strobes, edge_count unchanged. Then raw_in low held 10 cycles -> fall pulse and data_out=0 after edge 7; edge_count=2.
- raw_in high for 5 cycles, then reset for 1 cycle while raw_in stays high -> outputs 0 during reset. After deassert, rise occurs on the 7th edge with reset low; edge_count=1.
- Qualification-complete edge coincides with reset=1 -> no rise, data_out=0, edge_count=0.
- COUNT_W=2, 5 clean transitions each held 12 cycles -> edge_count sequence 1,2,3,0,1; exactly 5 enable pulses, alternating rise and fall.
